// File: rtl/mant_scheduler_pkg.sv
// Shared definitions for the maintenance scheduler.
//   state_e  : scheduler FSM states (IDLE, SERVICE, ERROR)
//   ERR_CODE : value shown on estado_reg while in ERROR
//   CNT_SAT  : saturation value of the completed-service count
//   sat_inc  : saturating increment of the service count
package mant_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    ERROR   = 2'd2
  } state_e;

  localparam logic [7:0] ERR_CODE = 8'hFF;
  localparam logic [7:0] CNT_SAT  = 8'hFE;

  // The count stops at CNT_SAT so it can never alias ERR_CODE.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == CNT_SAT) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mant_scheduler_rr_pick.sv
// Combinational round-robin picker.
//   req      : request vector, one bit per requester
//   last_idx : index of the most recently serviced requester
//   winner   : one-hot winner (all zero when req == 0)
//   win_idx  : index of the winner (0 when req == 0)
// The scan starts at last_idx+1 and wraps, so the last serviced
// requester has the lowest priority.
module rr_pick
  import mant_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] win_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    winner   = '0;
    win_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand     = (int'(last_idx) + i) % N_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!found && req[cand_idx]) begin
        found            = 1'b1;
        winner[cand_idx] = 1'b1;
        win_idx          = cand_idx;
      end
    end
  end

endmodule

// File: rtl/mant_scheduler.sv
// Maintenance scheduler: grants one requester at a time, round-robin,
// and watches for stalled service.
//   clk, rst   : clock, synchronous active-high reset
//   req        : level requests, one bit per requester
//   done       : one-cycle pulse ending the current service
//   grant      : registered one-hot grant
//   busy       : high while in SERVICE
//   err        : high while in ERROR (sticky until rst)
//   estado_reg : completed-service count, or ERR_CODE in ERROR
// Valid/ready view: a request is "valid" while its req bit is high; it is
// accepted on the edge that raises its grant bit, and the service is closed
// on the edge where done is high in SERVICE. req is not looked at in SERVICE.
module mant_scheduler
  import mant_scheduler_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WINDOW  = 200,
  parameter int SVC_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             err,
  output logic [7:0]       estado_reg
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int SVC_W = (SVC_MAX > 1) ? $clog2(SVC_MAX) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SVC_W-1:0] SVC_LAST = SVC_W'(SVC_MAX - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [7:0]       estado_q, estado_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [SVC_W-1:0] svc_q, svc_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req      (req),
    .last_idx (last_idx_q),
    .winner   (pick_onehot),
    .win_idx  (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    svc_d      = svc_q;
    last_idx_d = last_idx_q;
    cur_idx_d  = cur_idx_q;
    case (state_q)
      IDLE: begin
        win_d = win_q + 1'b1;
        // Window expiry outranks a new grant: nothing can complete in IDLE.
        if (win_q == WIN_LAST) begin
          state_d = ERROR;
          grant_d = '0;
        end else if (|req) begin
          state_d   = SERVICE;
          grant_d   = pick_onehot;
          cur_idx_d = pick_idx;
          svc_d     = '0;
        end
      end
      SERVICE: begin
        // done outranks both timeouts on the same edge.
        if (done) begin
          state_d    = IDLE;
          grant_d    = '0;
          last_idx_d = cur_idx_q;
          cnt_d      = sat_inc(cnt_q);
          win_d      = '0;
          svc_d      = '0;
        end else if ((win_q == WIN_LAST) || (svc_q == SVC_LAST)) begin
          state_d = ERROR;
          grant_d = '0;
        end else begin
          win_d = win_q + 1'b1;
          svc_d = svc_q + 1'b1;
        end
      end
      ERROR: begin
        grant_d = '0;
      end
      default: begin
        // Unreachable encoding: park in the safe sticky state.
        state_d = ERROR;
        grant_d = '0;
      end
    endcase
    busy_d   = (state_d == SERVICE);
    err_d    = (state_d == ERROR);
    estado_d = (state_d == ERROR) ? ERR_CODE : cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      estado_q   <= 8'h00;
      cnt_q      <= 8'h00;
      win_q      <= '0;
      svc_q      <= '0;
      last_idx_q <= IDX_W'(N_REQ - 1);
      cur_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      svc_q      <= svc_d;
      last_idx_q <= last_idx_d;
      cur_idx_q  <= cur_idx_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign estado_reg = estado_q;

endmodule

// File: tb/tb_mant_scheduler.sv
module tb_mant_scheduler;

  localparam int N_REQ   = 4;
  localparam int WINDOW  = 200;
  localparam int SVC_MAX = 16;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             err;
  logic [7:0]       estado_reg;

  always #5 clk = ~clk;

  mant_scheduler #(.N_REQ(N_REQ), .WINDOW(WINDOW), .SVC_MAX(SVC_MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .busy       (busy),
    .err        (err),
    .estado_reg (estado_reg)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Expected word layout: {grant[3:0], busy, err, estado[7:0]}
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [13:0] exp_q[$];

  task automatic check_sb(input string name);
    logic [13:0] e;
    logic [13:0] a;
    e = exp_q.pop_front();
    a = {grant, busy, err, estado_reg};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got grant=%b busy=%b err=%b estado=%h, expected grant=%b busy=%b err=%b estado=%h",
               name, a[13:10], a[9], a[8], a[7:0], e[13:10], e[9], e[8], e[7:0]);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] g, input logic b,
                            input logic e, input logic [7:0] s);
    exp_q.push_back({g, b, e, s});
    check_sb(name);
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic drive(input logic r, input logic [3:0] rq, input logic d);
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit m_err, m_busy;
  int m_gidx, m_last, m_count, m_since, m_age;

  task automatic model_reset();
    m_err = 0; m_busy = 0; m_gidx = -1; m_last = N_REQ - 1;
    m_count = 0; m_since = 0; m_age = 0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq, input logic d);
    if (r) begin
      model_reset();
    end else if (m_err) begin
      // sticky
    end else if (m_busy) begin
      if (d) begin
        m_busy  = 0;
        m_last  = m_gidx;
        m_gidx  = -1;
        m_count = (m_count + 1 > 254) ? 254 : m_count + 1;
        m_since = 0;
      end else if (m_since == WINDOW - 1 || m_age == SVC_MAX - 1) begin
        m_err = 1; m_busy = 0; m_gidx = -1;
      end else begin
        m_since++; m_age++;
      end
    end else begin
      if (m_since == WINDOW - 1) begin
        m_err = 1;
      end else begin
        m_since++;
        for (int k = 1; k <= N_REQ; k++) begin
          int idx;
          idx = (m_last + k) % N_REQ;
          if (!m_busy && rq[idx]) begin
            m_busy = 1; m_gidx = idx; m_age = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [13:0] model_out();
    logic [3:0] g;
    g = (m_gidx >= 0) ? 4'(1 << m_gidx) : 4'b0000;
    return {g, m_busy, m_err, m_err ? 8'hFF : 8'(m_count)};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic       b;
    logic       e;
    logic [7:0] s;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic set_v(input int i, input logic r, input logic [3:0] rq, input logic d,
                       input logic [3:0] g, input logic b, input logic e, input logic [7:0] s);
    vecs[i].rst = r; vecs[i].req = rq; vecs[i].done = d;
    vecs[i].g = g; vecs[i].b = b; vecs[i].e = e; vecs[i].s = s;
  endtask

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;

    // single requester, done three cycles after grant
    set_v(0,  1, 4'b0000, 0, 4'b0000, 0, 0, 8'h00);
    set_v(1,  0, 4'b0001, 0, 4'b0001, 1, 0, 8'h00);
    set_v(2,  0, 4'b0000, 0, 4'b0001, 1, 0, 8'h00);
    set_v(3,  0, 4'b0000, 0, 4'b0001, 1, 0, 8'h00);
    set_v(4,  0, 4'b0000, 1, 4'b0000, 0, 0, 8'h01);
    // all requesting: full rotation
    set_v(5,  1, 4'b0000, 0, 4'b0000, 0, 0, 8'h00);
    set_v(6,  0, 4'b1111, 0, 4'b0001, 1, 0, 8'h00);
    set_v(7,  0, 4'b1111, 1, 4'b0000, 0, 0, 8'h01);
    set_v(8,  0, 4'b1111, 0, 4'b0010, 1, 0, 8'h01);
    set_v(9,  0, 4'b1111, 1, 4'b0000, 0, 0, 8'h02);
    set_v(10, 0, 4'b1111, 0, 4'b0100, 1, 0, 8'h02);
    set_v(11, 0, 4'b1111, 1, 4'b0000, 0, 0, 8'h03);
    set_v(12, 0, 4'b1111, 0, 4'b1000, 1, 0, 8'h03);
    set_v(13, 0, 4'b1111, 1, 4'b0000, 0, 0, 8'h04);
    set_v(14, 0, 4'b1111, 0, 4'b0001, 1, 0, 8'h04);
    set_v(15, 0, 4'b1111, 1, 4'b0000, 0, 0, 8'h05);
    // done in IDLE ignored
    set_v(16, 0, 4'b0000, 1, 4'b0000, 0, 0, 8'h05);
    // reset mid-service drops the grant uncounted, priority restarts at 0
    set_v(17, 0, 4'b0100, 0, 4'b0100, 1, 0, 8'h05);
    set_v(18, 1, 4'b0100, 0, 4'b0000, 0, 0, 8'h00);
    set_v(19, 0, 4'b1111, 0, 4'b0001, 1, 0, 8'h00);
    set_v(20, 0, 4'b0000, 1, 4'b0000, 0, 0, 8'h01);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].done);
      expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].b, vecs[i].e, vecs[i].s);
    end

    // ---- window expiry with no requests, sticky ERROR, reset recovery ----
    drive(1, 4'b0000, 0);
    expect_out("win_rst", 4'b0000, 0, 0, 8'h00);
    for (int i = 0; i < WINDOW - 1; i++) drive(0, 4'b0000, 0);
    expect_out("win_edge199", 4'b0000, 0, 0, 8'h00);
    drive(0, 4'b0000, 0);
    expect_out("win_edge200", 4'b0000, 0, 1, 8'hFF);
    drive(0, 4'b1111, 1);
    expect_out("err_sticky_req_done", 4'b0000, 0, 1, 8'hFF);
    for (int i = 0; i < 3; i++) drive(0, 4'b1111, 0);
    expect_out("err_sticky_hold", 4'b0000, 0, 1, 8'hFF);
    drive(1, 4'b0000, 0);
    expect_out("err_rst_clear", 4'b0000, 0, 0, 8'h00);

    // ---- service timeout, late done ignored ----
    drive(0, 4'b0001, 0);
    expect_out("svc_grant", 4'b0001, 1, 0, 8'h00);
    for (int i = 0; i < SVC_MAX - 1; i++) drive(0, 4'b0001, 0);
    expect_out("svc_edge15", 4'b0001, 1, 0, 8'h00);
    drive(0, 4'b0001, 0);
    expect_out("svc_timeout", 4'b0000, 0, 1, 8'hFF);
    drive(0, 4'b0001, 1);
    expect_out("svc_late_done", 4'b0000, 0, 1, 8'hFF);
    drive(1, 4'b0000, 0);
    expect_out("svc_rst", 4'b0000, 0, 0, 8'h00);

    // ---- done on the service-timer expiry edge wins ----
    drive(0, 4'b0010, 0);
    expect_out("tie_svc_grant", 4'b0010, 1, 0, 8'h00);
    for (int i = 0; i < SVC_MAX - 1; i++) drive(0, 4'b0000, 0);
    drive(0, 4'b0000, 1);
    expect_out("tie_svc_done", 4'b0000, 0, 0, 8'h01);

    // ---- done on the window expiry edge wins, window restarts ----
    drive(1, 4'b0000, 0);
    for (int i = 0; i < 190; i++) drive(0, 4'b0000, 0);
    drive(0, 4'b0100, 0);
    expect_out("tie_win_grant", 4'b0100, 1, 0, 8'h00);
    for (int i = 0; i < 8; i++) drive(0, 4'b0000, 0);
    expect_out("tie_win_hold", 4'b0100, 1, 0, 8'h00);
    drive(0, 4'b0000, 1);
    expect_out("tie_win_done", 4'b0000, 0, 0, 8'h01);
    for (int i = 0; i < WINDOW - 1; i++) drive(0, 4'b0000, 0);
    expect_out("win_restart199", 4'b0000, 0, 0, 8'h01);
    drive(0, 4'b0000, 0);
    expect_out("win_restart200", 4'b0000, 0, 1, 8'hFF);

    // ---- randomized run against the reference model ----
    drive(1, 4'b0000, 0);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      logic       r;
      logic [3:0] rq;
      logic       d;
      int         done_pct;
      done_pct = (c / 500) % 3 == 0 ? 40 : ((c / 500) % 3 == 1 ? 12 : 3);
      r  = ($urandom_range(0, 149) == 0);
      rq = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      d  = ($urandom_range(0, 99) < done_pct);
      model_step(r, rq, d);
      exp_q.push_back(model_out());
      drive(r, rq, d);
      check_sb($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
